glitch_sweep: RTL and testbench

Sweep controller for the glitch engine's configuration FIFO. On a start command it walks a two-axis grid (glitch delay × glitch width) and pushes one 32-bit configuration word per grid point, optionally repeated, into the FIFO write port. This replaces the manual four-byte, per-word writes from the bus side. It sits in the `clk_i` domain between the register file and the FIFO write side; the FIFO and glitch core are unchanged.

---
 rtl/glitch_pkg.sv | 37 +++
 rtl/glitch_sweep.sv | 180 ++++++++++++++++++
 tb/tb_glitch_sweep.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/glitch_pkg.sv
// Shared definitions for the glitch sweep controller: states, word layout,
// and the register-file addresses that feed the sweep configuration.
package glitch_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_PUSH = 3'd2;
    localparam logic [2:0] ST_GAP  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    typedef logic [2:0] state_t;

    localparam int DLY_LSB = 0;
    localparam int WID_LSB = 16;

    localparam logic [7:0] GLITCH_SWEEP_CTRL   = 8'h40;
    localparam logic [7:0] GLITCH_DLY_START    = 8'h44;
    localparam logic [7:0] GLITCH_DLY_END      = 8'h48;
    localparam logic [7:0] GLITCH_DLY_STEP     = 8'h4C;
    localparam logic [7:0] GLITCH_WID_START    = 8'h50;
    localparam logic [7:0] GLITCH_WID_END      = 8'h54;
    localparam logic [7:0] GLITCH_WID_STEP     = 8'h58;
    localparam logic [7:0] GLITCH_SWEEP_REPS   = 8'h5C;
    localparam logic [7:0] GLITCH_SWEEP_STATUS = 8'h60;

    function automatic logic [31:0] pack_word(
        input logic [15:0] wid,
        input logic [15:0] dly
    );
        logic [31:0] w;
        w = '0;
        w[WID_LSB +: 16] = wid;
        w[DLY_LSB +: 16] = dly;
        return w;
    endfunction

endpackage

// File: rtl/glitch_sweep.sv
// Walks a delay x width grid and pushes one configuration word per point
// (optionally repeated) into the glitch engine's configuration FIFO.
module glitch_sweep
    import glitch_pkg::*;
#(
    parameter int DLY_W = 16,
    parameter int WID_W = 16,
    parameter int REP_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [DLY_W-1:0] dly_start_i,
    input  logic [DLY_W-1:0] dly_end_i,
    input  logic [DLY_W-1:0] dly_step_i,
    input  logic [WID_W-1:0] wid_start_i,
    input  logic [WID_W-1:0] wid_end_i,
    input  logic [WID_W-1:0] wid_step_i,
    input  logic [REP_W-1:0] reps_i,
    input  logic             fifo_full_i,
    output logic             fifo_we_o,
    output logic [31:0]      fifo_data_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             cfg_err_o,
    output logic [15:0]      word_cnt_o
);

    localparam logic [REP_W-1:0] REP_ONE = {{(REP_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [DLY_W-1:0] dly_s_q, dly_s_d, dly_e_q, dly_e_d;
    logic [DLY_W-1:0] dly_st_q, dly_st_d, cur_dly_q, cur_dly_d;
    logic [WID_W-1:0] wid_s_q, wid_s_d, wid_e_q, wid_e_d;
    logic [WID_W-1:0] wid_st_q, wid_st_d, cur_wid_q, cur_wid_d;
    logic [REP_W-1:0] reps_q, reps_d, rep_q, rep_d;
    logic [31:0]      data_q, data_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [DLY_W:0]   dly_nx;
    logic [WID_W:0]   wid_nx;
    logic             dly_ok, wid_ok, push;
    logic [REP_W-1:0] reps_eff;

    // An axis advances only on a nonzero step that neither carries out
    // of the field nor passes the end point.
    always_comb begin
        dly_nx   = {1'b0, cur_dly_q} + {1'b0, dly_st_q};
        wid_nx   = {1'b0, cur_wid_q} + {1'b0, wid_st_q};
        dly_ok   = (dly_st_q != '0) && !dly_nx[DLY_W]
                   && (dly_nx[DLY_W-1:0] <= dly_e_q);
        wid_ok   = (wid_st_q != '0) && !wid_nx[WID_W]
                   && (wid_nx[WID_W-1:0] <= wid_e_q);
        reps_eff = (reps_q == '0) ? REP_ONE : reps_q;
        push     = (state_q == ST_PUSH) && !fifo_full_i && !abort_i;
    end

    always_comb begin
        state_d   = state_q;
        dly_s_d   = dly_s_q;
        dly_e_d   = dly_e_q;
        dly_st_d  = dly_st_q;
        wid_s_d   = wid_s_q;
        wid_e_d   = wid_e_q;
        wid_st_d  = wid_st_q;
        reps_d    = reps_q;
        cur_dly_d = cur_dly_q;
        cur_wid_d = cur_wid_q;
        rep_d     = rep_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        if (state_q != ST_IDLE && abort_i) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i && !abort_i) begin
                        dly_s_d  = dly_start_i;
                        dly_e_d  = dly_end_i;
                        dly_st_d = dly_step_i;
                        wid_s_d  = wid_start_i;
                        wid_e_d  = wid_end_i;
                        wid_st_d = wid_step_i;
                        reps_d   = reps_i;
                        cnt_d    = '0;
                        err_d    = 1'b0;
                        state_d  = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (dly_s_q > dly_e_q || wid_s_q > wid_e_q) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        cur_dly_d = dly_s_q;
                        cur_wid_d = wid_s_q;
                        rep_d     = reps_eff;
                        data_d    = pack_word(wid_s_q, dly_s_q);
                        state_d   = ST_PUSH;
                    end
                end
                ST_PUSH: begin
                    if (!fifo_full_i) begin
                        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                        state_d = ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (rep_q > REP_ONE) begin
                        rep_d   = rep_q - REP_ONE;
                        state_d = ST_PUSH;
                    end else begin
                        rep_d = reps_eff;
                        if (dly_ok) begin
                            cur_dly_d = dly_nx[DLY_W-1:0];
                            data_d    = pack_word(cur_wid_q,
                                                  dly_nx[DLY_W-1:0]);
                            state_d   = ST_PUSH;
                        end else if (wid_ok) begin
                            cur_dly_d = dly_s_q;
                            cur_wid_d = wid_nx[WID_W-1:0];
                            data_d    = pack_word(wid_nx[WID_W-1:0],
                                                  dly_s_q);
                            state_d   = ST_PUSH;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            dly_s_q   <= '0;
            dly_e_q   <= '0;
            dly_st_q  <= '0;
            wid_s_q   <= '0;
            wid_e_q   <= '0;
            wid_st_q  <= '0;
            reps_q    <= '0;
            cur_dly_q <= '0;
            cur_wid_q <= '0;
            rep_q     <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dly_s_q   <= dly_s_d;
            dly_e_q   <= dly_e_d;
            dly_st_q  <= dly_st_d;
            wid_s_q   <= wid_s_d;
            wid_e_q   <= wid_e_d;
            wid_st_q  <= wid_st_d;
            reps_q    <= reps_d;
            cur_dly_q <= cur_dly_d;
            cur_wid_q <= cur_wid_d;
            rep_q     <= rep_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign fifo_we_o   = push;
    assign fifo_data_o = data_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_DONE) && !abort_i;
    assign cfg_err_o   = err_q;
    assign word_cnt_o  = cnt_q;

endmodule

// File: tb/tb_glitch_sweep.sv
// Directed and randomized sweeps of glitch_sweep against a grid-walking
// reference model.
module tb_glitch_sweep;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [15:0] dly_start_i = '0;
    logic [15:0] dly_end_i = '0;
    logic [15:0] dly_step_i = '0;
    logic [15:0] wid_start_i = '0;
    logic [15:0] wid_end_i = '0;
    logic [15:0] wid_step_i = '0;
    logic [7:0]  reps_i = '0;
    logic        fifo_full_i = 1'b0;
    logic        fifo_we_o;
    logic [31:0] fifo_data_o;
    logic        busy_o;
    logic        done_o;
    logic        cfg_err_o;
    logic [15:0] word_cnt_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic [31:0] mon_q[$];
    int          mon_cyc[$];
    logic [31:0] exp_q[$];

    glitch_sweep dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .dly_start_i (dly_start_i),
        .dly_end_i   (dly_end_i),
        .dly_step_i  (dly_step_i),
        .wid_start_i (wid_start_i),
        .wid_end_i   (wid_end_i),
        .wid_step_i  (wid_step_i),
        .reps_i      (reps_i),
        .fifo_full_i (fifo_full_i),
        .fifo_we_o   (fifo_we_o),
        .fifo_data_o (fifo_data_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .cfg_err_o   (cfg_err_o),
        .word_cnt_o  (word_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (fifo_we_o) begin
                chk("no_we_while_full", {31'b0, fifo_full_i}, 32'd0);
                mon_q.push_back(fifo_data_o);
                mon_cyc.push_back(cyc);
            end
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // Grid order: width outer, delay inner, repeats innermost.
    task automatic build_exp(input int ds, input int de, input int dst,
                             input int ws, input int we, input int wst,
                             input int reps);
        int r;
        exp_q.delete();
        if (ds > de || ws > we) return;
        r = (reps == 0) ? 1 : reps;
        for (int w = ws; w <= we; w = (wst == 0) ? we + 1 : w + wst)
            for (int d = ds; d <= de; d = (dst == 0) ? de + 1 : d + dst)
                for (int k = 0; k < r; k++)
                    exp_q.push_back({w[15:0], d[15:0]});
    endtask

    task automatic kick(input int ds, input int de, input int dst,
                        input int ws, input int we, input int wst,
                        input int reps, output int k);
        mon_q.delete();
        mon_cyc.delete();
        done_cnt = 0;
        @(posedge clk_i);
        #1;
        dly_start_i = ds[15:0];
        dly_end_i   = de[15:0];
        dly_step_i  = dst[15:0];
        wid_start_i = ws[15:0];
        wid_end_i   = we[15:0];
        wid_step_i  = wst[15:0];
        reps_i      = reps[7:0];
        start_i     = 1'b1;
        k = cyc;
    endtask

    // mode 0: never full, 1: random full, 2: full for 5 cycles after word 2
    task automatic run_sweep(input string tag, input int ds, input int de,
                             input int dst, input int ws, input int we,
                             input int wst, input int reps, input int mode);
        int  k;
        int  held;
        bit  seen;
        bit  exp_err;
        exp_err = (ds > de) || (ws > we);
        build_exp(ds, de, dst, ws, we, wst, reps);
        kick(ds, de, dst, ws, we, wst, reps, k);
        held = 0;
        seen = 1'b0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            @(posedge clk_i);
            #1;
            start_i = 1'b0;
            if (mode == 1) begin
                fifo_full_i = ($urandom_range(0, 2) == 0);
            end else if (mode == 2 && mon_q.size() >= 2 && held < 5) begin
                fifo_full_i = 1'b1;
                held++;
            end else begin
                fifo_full_i = 1'b0;
            end
            @(negedge clk_i);
            if (done_o) seen = 1'b1;
        end
        fifo_full_i = 1'b0;
        chk({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
        @(negedge clk_i);
        chk({tag, "_busy_low"}, {31'b0, busy_o}, 32'd0);
        chk({tag, "_nwords"}, mon_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < mon_q.size())
                chk($sformatf("%s_word%0d", tag, i), mon_q[i], exp_q[i]);
        chk({tag, "_word_cnt"}, {16'b0, word_cnt_o}, exp_q.size());
        chk({tag, "_done_cnt"}, done_cnt, 32'd1);
        chk({tag, "_cfg_err"}, {31'b0, cfg_err_o}, {31'b0, exp_err});
        if (mode == 0) begin
            if (exp_err)
                chk({tag, "_done_lat"}, done_cyc, k + 2);
            else if (mon_cyc.size() > 0)
                chk({tag, "_first_lat"}, mon_cyc[0], k + 2);
            if (mon_cyc.size() > 1)
                chk({tag, "_spacing"}, mon_cyc[1] - mon_cyc[0], 32'd2);
        end
    endtask

    initial begin
        int k;
        bit got;
        #1;
        chk("rst_we", {31'b0, fifo_we_o}, 32'd0);
        chk("rst_data", fifo_data_o, 32'd0);
        chk("rst_busy", {31'b0, busy_o}, 32'd0);
        chk("rst_done", {31'b0, done_o}, 32'd0);
        chk("rst_cfg_err", {31'b0, cfg_err_o}, 32'd0);
        chk("rst_cnt", {16'b0, word_cnt_o}, 32'd0);
        #10;
        rst_ni = 1'b1;
        @(negedge clk_i);

        run_sweep("basic", 10, 30, 10, 5, 6, 1, 1, 0);
        run_sweep("step0_rep0", 7, 7, 0, 3, 3, 0, 0, 0);
        run_sweep("step0_rep3", 7, 7, 0, 3, 3, 0, 3, 0);
        run_sweep("backpressure", 10, 30, 10, 5, 6, 1, 1, 2);
        run_sweep("overflow", 16'hFFF0, 16'hFFFF, 16'h20, 1, 1, 0, 1, 0);
        run_sweep("cfg_err", 50, 40, 1, 1, 2, 1, 1, 0);

        build_exp(10, 30, 10, 5, 6, 1, 1);
        kick(10, 30, 10, 5, 6, 1, 1, k);
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk_i);
            #1;
            start_i = 1'b0;
            @(negedge clk_i);
            if (mon_q.size() >= 2) got = 1'b1;
        end
        chk("abort_two_words", {31'b0, got}, 32'd1);
        @(posedge clk_i);
        #1;
        abort_i = 1'b1;
        @(posedge clk_i);
        #1;
        abort_i = 1'b0;
        @(negedge clk_i);
        chk("abort_busy_low", {31'b0, busy_o}, 32'd0);
        repeat (10) @(negedge clk_i);
        chk("abort_nwords", mon_q.size(), 32'd2);
        chk("abort_word1", mon_q[1], exp_q[1]);
        chk("abort_no_done", done_cnt, 32'd0);
        chk("abort_cnt", {16'b0, word_cnt_o}, 32'd2);

        run_sweep("restart", 10, 30, 10, 5, 6, 1, 1, 0);

        kick(10, 30, 10, 5, 6, 1, 1, k);
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk_i);
            #1;
            start_i = 1'b0;
            @(negedge clk_i);
            if (mon_q.size() >= 3) got = 1'b1;
        end
        chk("rst_mid_reached", {31'b0, got}, 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("rst_mid_we", {31'b0, fifo_we_o}, 32'd0);
        chk("rst_mid_data", fifo_data_o, 32'd0);
        chk("rst_mid_busy", {31'b0, busy_o}, 32'd0);
        chk("rst_mid_done", {31'b0, done_o}, 32'd0);
        chk("rst_mid_err", {31'b0, cfg_err_o}, 32'd0);
        chk("rst_mid_cnt", {16'b0, word_cnt_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        run_sweep("after_reset", 10, 30, 10, 5, 6, 1, 1, 0);

        for (int n = 0; n < 12; n++) begin
            int ds, de, dst, ws, we, wst, reps, mode;
            ds  = $urandom_range(0, 16'hFFFF);
            de  = ds + $urandom_range(0, 40);
            if (de > 16'hFFFF) de = 16'hFFFF;
            dst = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(4, 20);
            if ($urandom_range(0, 3) == 0) begin
                de = 16'hFFFF;
                ds = 16'hFFFF - $urandom_range(0, 40);
            end
            if ($urandom_range(0, 7) == 0 && de < 16'hFFFF) ds = de + 1;
            ws  = $urandom_range(0, 16'hFFFF);
            we  = ws + $urandom_range(0, 40);
            if (we > 16'hFFFF) we = 16'hFFFF;
            wst = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(4, 20);
            if ($urandom_range(0, 7) == 0 && we < 16'hFFFF) ws = we + 1;
            reps = $urandom_range(0, 3);
            mode = $urandom_range(0, 1);
            run_sweep($sformatf("rnd%0d", n), ds, de, dst, ws, we, wst,
                      reps, mode);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
